seq_done_sink: RTL and testbench
================================

Name: seq_done_sink

Overview:
- Receiving end of the `seq_logic` counter interface: watches `q_in` (count) and `done_in`, and captures one event per `done` rising edge.
- Each event holds the count value and a free-running cycle timestamp; it is buffered in a small FIFO and drained by a downstream reader over a valid/ready handshake.
- Sits between the sequence counter and any consumer (status register, logger), replacing the bench-only event mechanism with synthesizable RTL.

Parameters:
- CNT_W, 2, width of the counter value on `q_in`.
- STAMP_W, 16, width of the free-running cycle timestamp.
- DEPTH, 4, FIFO depth in events; must be a power of 2, at least 2.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- q_in  in  CNT_W  count value from the sequence counter.
- done_in  in  1  terminal-count flag from the sequence counter (level).
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  reader accepts the head event.
- evt_count  out  CNT_W  `q_in` captured at the done edge.
- evt_stamp  out  STAMP_W  timestamp captured at the done edge.
- overflow  out  1  sticky: at least one event was dropped.
- drop_cnt  out  DROP_W  number of dropped events, saturating.
- seq_err  out  1  sticky sequence-check error (optional feature).

Behaviour:
- Reset (async assert, sync release): all outputs, `done_q`, the stamp counter, FIFO pointers and occupancy go to 0. Reset mid-operation discards all buffered events.
- Stamp counter: increments every cycle out of reset and wraps from 2^STAMP_W-1 to 0.
- Edge detect: `done_q` registers `done_in`. Push condition: `push = done_in & ~done_q`.
  - A `done_in` held high for N cycles yields exactly one event.
  - A first-cycle-after-reset `done_in`=1 counts as a rising edge.
- Capture: on the push edge, `{q_in, stamp}` is written to the FIFO. `evt_valid` rises the following cycle (1-cycle latency from sampled `done_in`).
- Read: show-ahead FIFO. `evt_count`/`evt_stamp` show the head whenever `evt_valid`=1; they are 0 when empty.
  - Pop when `evt_valid & evt_ready`.
  - `evt_ready` while empty is ignored.
- Full:
  - Push while full with no pop: event dropped, `overflow` set (sticky until reset), `drop_cnt` += 1, saturating at 2^DROP_W-1.
  - Push while full with a simultaneous pop: push accepted, nothing dropped, occupancy unchanged.
- Empty with simultaneous push and pop: the pop is ignored, because `evt_valid`=0 in that cycle; the event is written.
- Pointers: log2(DEPTH) bits, natural wrap. Occupancy is a separate counter of width log2(DEPTH)+1.
- Handshake stability: while `evt_valid`=1 and `evt_ready`=0, the head outputs hold stable.

Optional Feature:
- Macro: `SEQ_DONE_SINK_CHECK_EN`.
- Defined: a checker registers the previous `q_in` and sets sticky `seq_err` when either condition holds:
  - `q_in` ≠ (prev+1) mod 2^CNT_W and `q_in` ≠ prev (a skip); or
  - `done_in`=1 while `q_in` ≠ 2^CNT_W-1.
- The checker is disarmed for the first cycle after reset; `seq_err` clears only on reset.
- Not defined: `seq_err` tied to 0 and no checker logic is generated.

Decomposition:
- Package `seq_pkg`:
  - `CNT_W_DEF` and `STAMP_W_DEF` constants.
  - Typedef `seq_evt_t` struct {count, stamp}, parameterized via package localparams.
  - `function` returning the max count.
- Sub-module `seq_evt_fifo`: generic show-ahead sync FIFO with push/pop/full/empty/occupancy. `seq_done_sink` instantiates it and owns edge detect, stamp, drop logic and checker.

Test Plan:
- Reset release, counter runs 0,1,2,3,0…, `done_in`=1 at `q_in`=3 for 1 cycle, `evt_ready`=1 → exactly one event per wrap; `evt_count`=3; `evt_stamp` increases by 4 per event; `seq_err`=0.
- `done_in` held high 3 cycles → one event only; FIFO occupancy 1.
- `evt_ready`=0, 6 done edges with DEPTH=4 → 4 events stored; `overflow`=1; `drop_cnt`=2. Then drain → 4 events in order, stamps ascending, then `evt_valid`=0.
- FIFO full plus push and pop in the same cycle → `drop_cnt` unchanged, occupancy stays 4, oldest event popped, newest appended.
- Assert `reset_n`=0 with 3 events queued mid-drain → `evt_valid`, `overflow`, `drop_cnt` and stamp all 0 immediately (async); after release, the first new event has a stamp near 0.
- With `SEQ_DONE_SINK_CHECK_EN`: `q_in` sequence 0,1,3 → `seq_err`=1 and it stays 1. `done_in`=1 at `q_in`=2 → `seq_err`=1. Without the macro: same stimulus → `seq_err`=0.

Source files
------------

// File: rtl/seq_done_sink_pkg.sv
// Shared types and constants for the sequence-done event sink.
// Default widths here match the seq_logic counter and the sink's default parameters.
package seq_pkg;

  localparam int CNT_W_DEF   = 2;
  localparam int STAMP_W_DEF = 16;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]   count;
    logic [STAMP_W_DEF-1:0] stamp;
  } seq_evt_t;

  // Terminal count of a w-bit up-counter.
  function automatic int unsigned seq_max_count(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_done_sink_if.sv
// Event read-out handshake between the done sink (master) and its reader (slave).
interface seq_done_sink_if
  import seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STAMP_W = STAMP_W_DEF
);

  logic               evt_valid;
  logic               evt_ready;
  logic [CNT_W-1:0]   evt_count;
  logic [STAMP_W-1:0] evt_stamp;

  modport master (
    output evt_valid,
    output evt_count,
    output evt_stamp,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_count,
    input  evt_stamp,
    output evt_ready
  );

endinterface

// File: rtl/seq_done_sink_evt_fifo.sv
// Generic show-ahead synchronous FIFO; the head word reads as zero while empty.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module seq_evt_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; the empty gate on dout hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/seq_done_sink.sv
// Captures one {count, stamp} event per rising edge of done_in and queues it for a reader.
// Optional sequence checker enabled by defining SEQ_DONE_SINK_CHECK_EN.
module seq_done_sink
  import seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int STAMP_W = STAMP_W_DEF,
  parameter int DEPTH   = 4,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              done_in,
  seq_done_sink_if.master   evt,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              seq_err
);

  localparam int EVT_W = CNT_W + STAMP_W;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic               done_q;
  logic [STAMP_W-1:0] stamp;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;
  logic               empty;
  logic [OCC_W-1:0]   occ;
  logic [EVT_W-1:0]   head;

  assign push = done_in & ~done_q;
  assign pop  = evt.evt_ready & (occ != '0);
  assign drop = push & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      stamp    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done_q <= done_in;
      stamp  <= stamp + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  seq_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push & ~drop),
    .pop     (pop),
    .din     ({q_in, stamp}),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .occ     (occ)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_count = head[EVT_W-1:STAMP_W];
  assign evt.evt_stamp = head[STAMP_W-1:0];

`ifdef SEQ_DONE_SINK_CHECK_EN
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] prev_inc;
  logic             armed;
  logic             skip;
  logic             bad_done;

  assign prev_inc = prev_q + 1'b1;
  assign skip     = (q_in != prev_inc) && (q_in != prev_q);
  assign bad_done = done_in && (q_in != CNT_W'(seq_max_count(CNT_W)));

  // prev_q is meaningless until one sample has been taken after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      armed   <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      prev_q <= q_in;
      armed  <= 1'b1;
      if (armed && (skip || bad_done)) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_done_sink.sv
// Randomized and directed bench for seq_done_sink against a queue-based event model.
module tb_seq_done_sink;
  import seq_pkg::*;

  localparam int DEPTH = 4;
`ifdef SEQ_DONE_SINK_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] q_in = '0;
  logic       done_in = 1'b0;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       seq_err;

  seq_done_sink_if evt_if ();

  seq_done_sink #(.CNT_W(2), .STAMP_W(16), .DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .q_in     (q_in),
    .done_in  (done_in),
    .evt      (evt_if.master),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  seq_evt_t    mq[$];
  int unsigned m_stamp;
  bit          m_ovf;
  int          m_drop;
  bit          m_done_q;
  bit          m_err;
  bit          m_armed;
  logic [1:0]  m_prev;
  logic [1:0]  cur_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_stamp  = 0;
    m_ovf    = 0;
    m_drop   = 0;
    m_done_q = 0;
    m_err    = 0;
    m_armed  = 0;
    m_prev   = '0;
  endtask

  task automatic compare_all();
    logic [1:0]  ec;
    logic [15:0] es;
    ec = '0;
    es = '0;
    if (mq.size() > 0) begin
      ec = mq[0].count;
      es = mq[0].stamp;
    end
    check("valid", 32'(evt_if.evt_valid), 32'(mq.size() > 0));
    check("count", 32'(evt_if.evt_count), 32'(ec));
    check("stamp", 32'(evt_if.evt_stamp), 32'(es));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("seq_err", 32'(seq_err), 32'(m_err));
  endtask

  // One clock of the spec's behaviour, evaluated on the inputs present at the edge.
  task automatic model_update(input logic [1:0] q, input logic d, input logic r);
    seq_evt_t   ev;
    bit         do_pop;
    bit         do_push;
    logic [1:0] nxt;
    do_pop  = (mq.size() > 0) && r;
    do_push = d && !m_done_q;
    if (do_pop) ev = mq.pop_front();
    if (do_push) begin
      if (mq.size() == DEPTH) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else begin
        ev.count = q;
        ev.stamp = m_stamp[15:0];
        mq.push_back(ev);
      end
    end
    m_done_q = d;
`ifdef SEQ_DONE_SINK_CHECK_EN
    nxt = m_prev + 2'd1;
    if (m_armed && (((q != nxt) && (q != m_prev)) || (d && q != 2'd3))) m_err = 1;
    m_prev  = q;
    m_armed = 1;
`else
    nxt = '0;
`endif
    m_stamp = (m_stamp + 1) & 32'hffff;
  endtask

  // Entered and left at a negedge.
  task automatic step(input logic [1:0] q, input logic d, input logic r);
    compare_all();
    q_in             = q;
    done_in          = d;
    evt_if.evt_ready = r;
    @(posedge clk);
    model_update(q, d, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    q_in             = '0;
    done_in          = 1'b0;
    evt_if.evt_ready = 1'b0;
    #1;
    model_clear();
    compare_all();
    check("rst_stamp", 32'(dut.stamp), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    evt_if.evt_ready = 1'b0;
    model_clear();
    @(negedge clk);

    // Free-running counter, done at terminal count, first cycle done=1 after reset.
    do_reset();
    for (int i = 3; i < 43; i++) step(2'(i % 4), (i % 4) == 3, 1'b1);
    check("wrap_no_err", 32'(seq_err), 32'd0);

    // done held three cycles yields a single event.
    do_reset();
    step(2'd0, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'd3, 1'b1, 1'b0);
    step(2'd0, 1'b0, 1'b0);
    check("hold_valid", 32'(evt_if.evt_valid), 32'd1);
    step(2'd1, 1'b0, 1'b1);
    check("hold_single", 32'(evt_if.evt_valid), 32'd0);

    // Six edges into a four-deep FIFO, then drain in order.
    do_reset();
    step(2'd0, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(2'd3, 1'b1, 1'b0);
      step(2'd3, 1'b0, 1'b0);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1);
    check("drained", 32'(evt_if.evt_valid), 32'd0);

    // Full with push and pop in the same cycle.
    do_reset();
    step(2'd0, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'd3, 1'b1, 1'b0);
      step(2'd3, 1'b0, 1'b0);
    end
    step(2'd3, 1'b1, 1'b1);
    check("full_pp_drops", 32'(drop_cnt), 32'd0);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) step(2'd3, 1'b0, 1'b1);

    // Reset with events queued mid-drain.
    do_reset();
    step(2'd0, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(2'd3, 1'b1, 1'b0);
      step(2'd3, 1'b0, 1'b0);
    end
    step(2'd3, 1'b0, 1'b1);
    do_reset();
    step(2'd3, 1'b1, 1'b0);
    step(2'd0, 1'b0, 1'b0);
    check("post_rst_stamp", 32'(evt_if.evt_stamp), 32'd0);

    // Drop counter saturation.
    do_reset();
    step(2'd0, 1'b0, 1'b0); step(2'd1, 1'b0, 1'b0); step(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 262; i++) begin
      step(2'd3, 1'b1, 1'b0);
      step(2'd3, 1'b0, 1'b0);
    end
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Random legal counter walk with random reader back-pressure.
    do_reset();
    cur_q = '0;
    for (int i = 0; i < 500; i++) begin
      logic d;
      if ($urandom_range(0, 2) == 0) cur_q = cur_q + 2'd1;
      d = (cur_q == 2'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(cur_q, d, 1'($urandom_range(0, 1)));
    end
    check("rand_no_err", 32'(seq_err), 32'd0);

    // Sequence checker: skip 1 -> 3, then done at non-terminal count.
    do_reset();
    step(2'd0, 1'b0, 1'b1); step(2'd1, 1'b0, 1'b1); step(2'd3, 1'b0, 1'b1);
    check("skip_err", 32'(seq_err), 32'(EXP_ERR));
    step(2'd0, 1'b0, 1'b1); step(2'd1, 1'b0, 1'b1); step(2'd2, 1'b0, 1'b1);
    check("skip_sticky", 32'(seq_err), 32'(EXP_ERR));
    do_reset();
    step(2'd0, 1'b0, 1'b1); step(2'd1, 1'b0, 1'b1); step(2'd2, 1'b0, 1'b1);
    check("pre_done_err", 32'(seq_err), 32'd0);
    step(2'd2, 1'b1, 1'b1); step(2'd3, 1'b0, 1'b1); step(2'd0, 1'b0, 1'b1);
    check("early_done_err", 32'(seq_err), 32'(EXP_ERR));
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
